// File: rtl/sim_clk_sequencer_pkg.sv
// Shared types and default parameters for the simulation clock sequencer.
package sim_clk_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  localparam int unsigned DEF_WARMUP_CYCLES = 16;
  localparam int unsigned DEF_DRAIN_SAMPLES = 4;
  localparam int unsigned DEF_MAX_SAMPLES   = 0;
  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned PHASE_CTR_W       = 32;

  // WARMUP, RUN and DRAIN are the phases in which generated clocks run.
  function automatic logic is_active(input seq_state_e s);
    return (s == ST_WARMUP) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sim_seq_counter.sv
// Loadable down-counter that times both the warm-up and the drain phase.
module sim_seq_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A load always takes precedence; decrementing stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign one_o  = (count_q == W'(1));

endmodule

// File: rtl/sim_clk_sequencer.sv
// Run-phase sequencer for a simulation harness: gates clocks, file reading
// and output writing through warm-up, run and drain phases.
module sim_clk_sequencer
  import sim_clk_sequencer_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned DRAIN_SAMPLES = DEF_DRAIN_SAMPLES,
  parameter int unsigned MAX_SAMPLES   = DEF_MAX_SAMPLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             eof,
  input  logic             sample_tick,
  output logic             clk_enable,
  output logic             read_en,
  output logic             write_en,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]       MAX_C     = CNT_W'(MAX_SAMPLES);
  localparam logic [PHASE_CTR_W-1:0] WARMUP_C  = PHASE_CTR_W'(WARMUP_CYCLES);
  localparam logic [PHASE_CTR_W-1:0] DRAIN_C   = PHASE_CTR_W'(DRAIN_SAMPLES);

  seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic aborted_q, aborted_d;
  logic active_q, read_en_q, write_en_q, done_q;

  logic ctr_load;
  logic [PHASE_CTR_W-1:0] ctr_val;
  logic ctr_dec;
  logic ctr_zero;
  logic ctr_one;
  logic start_ok;

  sim_seq_counter #(
    .W (PHASE_CTR_W)
  ) u_phase_ctr (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero),
    .one_o      (ctr_one)
  );

  // A simultaneous stop cancels a start request.
  assign start_ok = start && !stop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    ctr_load  = 1'b0;
    ctr_val   = '0;
    ctr_dec   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          cnt_d     = '0;
          aborted_d = 1'b0;
          if (WARMUP_CYCLES == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_WARMUP;
            ctr_load = 1'b1;
            ctr_val  = WARMUP_C;
          end
        end
      end

      ST_WARMUP: begin
        if (stop) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          ctr_dec = 1'b1;
          if (ctr_one || ctr_zero) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // A tick coinciding with an exit condition is still counted.
        if (sample_tick && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (stop) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (eof || ((MAX_SAMPLES != 0) && (cnt_d >= MAX_C))) begin
          state_d  = ST_DRAIN;
          ctr_load = 1'b1;
          ctr_val  = DRAIN_C;
        end
      end

      ST_DRAIN: begin
        if (stop) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (ctr_zero) begin
          state_d = ST_DONE;
        end else if (sample_tick) begin
          ctr_dec = 1'b1;
          if (ctr_one) begin
            state_d = ST_DONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      aborted_q  <= 1'b0;
      active_q   <= 1'b0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aborted_q  <= aborted_d;
      active_q   <= is_active(state_d);
      read_en_q  <= (state_d == ST_RUN);
      write_en_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign clk_enable = active_q;
  assign busy       = active_q;
  assign read_en    = read_en_q;
  assign write_en   = write_en_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sim_clk_sequencer.sv
// Scoreboard bench: two sequencer configurations share one stimulus stream and
// are compared every cycle against a phase-level reference model.
module tb_sim_clk_sequencer;
  import sim_clk_sequencer_pkg::*;

  localparam int A_WARM  = int'(DEF_WARMUP_CYCLES);
  localparam int A_DRAIN = int'(DEF_DRAIN_SAMPLES);
  localparam int A_MAX   = 10;
  localparam longint unsigned A_SAT = 64'hFFFF_FFFF;
  localparam int B_CNT_W = 3;
  localparam longint unsigned B_SAT = 64'd7;

  localparam int PH_IDLE  = 0;
  localparam int PH_WARM  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DRAIN = 3;
  localparam int PH_DONE  = 4;

  typedef struct {
    int              phase;
    longint unsigned cnt;
    int              elapsed;
    int              drained;
    bit              ab;
  } model_t;

  typedef struct {
    bit              ce;
    bit              re;
    bit              we;
    bit              busy;
    bit              done;
    bit              ab;
    longint unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, stop, eof, sample_tick;

  logic ceA, reA, weA, busyA, doneA, abA;
  logic [31:0] cntA;
  logic ceB, reB, weB, busyB, doneB, abB;
  logic [B_CNT_W-1:0] cntB;

  exp_t   qA[$];
  exp_t   qB[$];
  model_t mA, mB;
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;

  always #5 clk = ~clk;

  sim_clk_sequencer #(
    .WARMUP_CYCLES (DEF_WARMUP_CYCLES),
    .DRAIN_SAMPLES (DEF_DRAIN_SAMPLES),
    .MAX_SAMPLES   (A_MAX),
    .CNT_W         (32)
  ) dutA (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .eof         (eof),
    .sample_tick (sample_tick),
    .clk_enable  (ceA),
    .read_en     (reA),
    .write_en    (weA),
    .sample_cnt  (cntA),
    .busy        (busyA),
    .done        (doneA),
    .aborted     (abA)
  );

  sim_clk_sequencer #(
    .WARMUP_CYCLES (0),
    .DRAIN_SAMPLES (0),
    .MAX_SAMPLES   (0),
    .CNT_W         (B_CNT_W)
  ) dutB (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .eof         (eof),
    .sample_tick (sample_tick),
    .clk_enable  (ceB),
    .read_en     (reB),
    .write_en    (weB),
    .sample_cnt  (cntB),
    .busy        (busyB),
    .done        (doneB),
    .aborted     (abB)
  );

  function automatic model_t resetModel();
    model_t n;
    n.phase   = PH_IDLE;
    n.cnt     = 0;
    n.elapsed = 0;
    n.drained = 0;
    n.ab      = 1'b0;
    return n;
  endfunction

  // One clock edge of the run-phase rules, counting phase progress upward.
  function automatic model_t step(input model_t m, input int warm, input int drn,
                                  input longint unsigned mx, input longint unsigned sat,
                                  input bit r, input bit st, input bit sp,
                                  input bit ef, input bit tk);
    model_t n;
    n = m;
    if (!r) return resetModel();
    case (m.phase)
      PH_IDLE, PH_DONE: begin
        if (st && !sp) begin
          n.cnt     = 0;
          n.ab      = 1'b0;
          n.elapsed = 0;
          n.phase   = (warm == 0) ? PH_RUN : PH_WARM;
        end
      end
      PH_WARM: begin
        if (sp) begin
          n.phase = PH_DONE;
          n.ab    = 1'b1;
        end else begin
          n.elapsed = m.elapsed + 1;
          if (n.elapsed >= warm) n.phase = PH_RUN;
        end
      end
      PH_RUN: begin
        if (tk && (m.cnt < sat)) n.cnt = m.cnt + 1;
        if (sp) begin
          n.phase = PH_DONE;
          n.ab    = 1'b1;
        end else if (ef || ((mx != 0) && (n.cnt >= mx))) begin
          n.phase   = PH_DRAIN;
          n.drained = 0;
        end
      end
      PH_DRAIN: begin
        if (sp) begin
          n.phase = PH_DONE;
          n.ab    = 1'b1;
        end else if (drn == 0) begin
          n.phase = PH_DONE;
        end else if (tk) begin
          n.drained = m.drained + 1;
          if (n.drained >= drn) n.phase = PH_DONE;
        end
      end
      default: n = resetModel();
    endcase
    return n;
  endfunction

  function automatic exp_t outputsOf(input model_t m);
    exp_t e;
    e.ce   = (m.phase == PH_WARM) || (m.phase == PH_RUN) || (m.phase == PH_DRAIN);
    e.re   = (m.phase == PH_RUN);
    e.we   = (m.phase == PH_RUN) || (m.phase == PH_DRAIN);
    e.busy = e.ce;
    e.done = (m.phase == PH_DONE);
    e.ab   = m.ab;
    e.cnt  = m.cnt;
    return e;
  endfunction

  // Drives one cycle of inputs and queues the response expected after the edge.
  task automatic applyStimulus(input bit r, input bit st, input bit sp,
                               input bit ef, input bit tk);
    @(negedge clk);
    rst_n       = r;
    start       = st;
    stop        = sp;
    eof         = ef;
    sample_tick = tk;
    mA = step(mA, A_WARM, A_DRAIN, longint'(A_MAX), A_SAT, r, st, sp, ef, tk);
    mB = step(mB, 0, 0, 0, B_SAT, r, st, sp, ef, tk);
    qA.push_back(outputsOf(mA));
    qB.push_back(outputsOf(mB));
  endtask

  task automatic checkOutput(input string tag, input exp_t e,
                             input bit ce, input bit re, input bit we,
                             input bit bs, input bit dn, input bit ab,
                             input longint unsigned cnt);
    checks++;
    if (ce !== e.ce || re !== e.re || we !== e.we || bs !== e.busy ||
        dn !== e.done || ab !== e.ab || cnt != e.cnt) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got ce=%0b re=%0b we=%0b busy=%0b done=%0b ab=%0b cnt=%0d expected ce=%0b re=%0b we=%0b busy=%0b done=%0b ab=%0b cnt=%0d",
               tag, cyc, ce, re, we, bs, dn, ab, cnt,
               e.ce, e.re, e.we, e.busy, e.done, e.ab, e.cnt);
    end
  endtask

  // Monitor: pops expectations after each edge and checks warm-up length independently.
  initial begin : monitor
    exp_t e;
    int   ceRiseCyc;
    bit   prevCe, prevRe;
    ceRiseCyc = -1000;
    prevCe    = 1'b0;
    prevRe    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qA.size() > 0) begin
        e = qA.pop_front();
        checkOutput("dutA", e, ceA, reA, weA, busyA, doneA, abA, 64'(cntA));
        if (ceA && !prevCe) ceRiseCyc = cyc;
        if (reA && !prevRe) begin
          checks++;
          if (cyc - ceRiseCyc != A_WARM) begin
            failures++;
            $display("[TB] FAIL warmup_len got=%0d expected=%0d", cyc - ceRiseCyc, A_WARM);
          end
        end
        prevCe = ceA;
        prevRe = reA;
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        checkOutput("dutB", e, ceB, reB, weB, busyB, doneB, abB, 64'(cntB));
      end
    end
  end

  initial begin : driver
    bit efHeld;
    bit tk, ef, sp;
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    eof         = 1'b0;
    sample_tick = 1'b0;
    mA = resetModel();
    mB = resetModel();

    repeat (3) applyStimulus(0, 0, 0, 0, 0);

    // Full run limited by MAX_SAMPLES; dutB saturates its narrow counter.
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 150 && mA.phase != PH_DONE; i++) applyStimulus(1, 0, 0, 0, (i % 2) == 1);
    repeat (2) applyStimulus(1, 0, 0, 0, 0);

    // Restart from DONE; eof arrives together with the fifth tick.
    applyStimulus(1, 1, 0, 0, 0);
    efHeld = 1'b0;
    for (int i = 0; i < 150 && mA.phase != PH_DONE; i++) begin
      tk = (i % 2) == 1;
      ef = efHeld || (tk && mA.phase == PH_RUN && mA.cnt == 4);
      efHeld = ef;
      applyStimulus(1, 0, 0, ef, tk);
    end
    repeat (2) applyStimulus(1, 0, 0, 0, 0);

    // Abort during RUN once three samples have been taken.
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 150 && !(mA.phase == PH_RUN && mA.cnt == 3); i++)
      applyStimulus(1, 0, 0, 0, (mA.phase == PH_RUN) && (i % 2 == 0));
    applyStimulus(1, 0, 1, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0);

    // eof already high when RUN is entered.
    applyStimulus(1, 1, 0, 1, 0);
    for (int i = 0; i < 150 && mA.phase != PH_DONE; i++) applyStimulus(1, 0, 0, 1, (i % 3) == 0);
    applyStimulus(1, 0, 0, 0, 0);

    // start and stop together in DONE, then in IDLE after reset.
    applyStimulus(1, 1, 1, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0);

    // Reset while draining.
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 150 && mA.phase != PH_DRAIN; i++) applyStimulus(1, 0, 0, mA.phase == PH_RUN, 1'b0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0);

    // Randomised traffic.
    efHeld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sp = ($urandom_range(0, 49) == 0);
      tk = !sp && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) efHeld = !efHeld;
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0, sp, efHeld, tk);
    end

    @(posedge clk);
    #2;
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d/%0d pending expected=0", qA.size(), qB.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
